// File: rtl/neuron_mac_engine.sv
// Multi-cycle neuron: LANES-wide signed MAC over N elements, scaled bias, optional FRAC rescale, saturating ReLU.
// Define NEURON_LEAKY_RELU_EN for a leaky negative slope (s >>> 3, clamped to the most negative DW value).
module neuron_mac_lane #(
  parameter int DW    = 8,
  parameter int ACC_W = 21
) (
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] prod
);
  logic signed [2*DW-1:0] w_p;
  assign w_p  = a * b;
  assign prod = en ? ACC_W'(w_p) : '0;
endmodule

module neuron_mac_engine #(
  parameter int N     = 10,
  parameter int DW    = 8,
  parameter int LANES = 1,
  parameter int FRAC  = 7,
  parameter int ACC_W = 21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW*N-1:0] inp,
  input  logic [DW*N-1:0] w,
  input  logic [DW-1:0]   bias,
  input  logic            hidden,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   result
);
  localparam int IW = $clog2(N + LANES + 1);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((1 << (DW - 1)) - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_ACT} state_t;
  state_t r_state, w_nxt;

  logic [N-1:0][DW-1:0]            r_inp, r_w;
  logic signed [DW-1:0]            r_bias;
  logic                            r_hidden;
  logic signed [ACC_W-1:0]         r_acc;
  logic [IW-1:0]                   r_idx;
  logic                            r_done;
  logic [DW-1:0]                   r_result;
  logic [LANES-1:0][ACC_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]         w_sum, w_s, w_bias_sc;
  logic                            w_last;
  logic [DW-1:0]                   w_y;

  // Lanes past the last element are gated off and read a safe index.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0] w_eidx;
    logic          w_en;
    logic [SW-1:0] w_sidx;
    assign w_eidx = r_idx + IW'(l);
    assign w_en   = w_eidx < IW'(N);
    assign w_sidx = w_en ? w_eidx[SW-1:0] : '0;
    neuron_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .en  (w_en),
      .a   (r_inp[w_sidx]),
      .b   (r_w[w_sidx]),
      .prod(w_prod[l])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) w_sum = w_sum + $signed(w_prod[l]);
  end

  assign w_last    = (r_idx + IW'(LANES)) >= IW'(N);
  assign w_bias_sc = ACC_W'(r_bias) <<< FRAC;
  assign w_s       = r_hidden ? (r_acc >>> FRAC) : r_acc;

`ifdef NEURON_LEAKY_RELU_EN
  logic signed [ACC_W-1:0] w_lk;
  assign w_lk = w_s >>> 3;
`endif

  always_comb begin
    w_y = w_s[DW-1:0];
    if (w_s[ACC_W-1]) begin
`ifdef NEURON_LEAKY_RELU_EN
      w_y = (w_lk < ~YMAX) ? ~YMAX[DW-1:0] : w_lk[DW-1:0];
`else
      w_y = '0;
`endif
    end else if (w_s > YMAX) begin
      w_y = YMAX[DW-1:0];
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_nxt = S_MAC;
      S_MAC:  if (w_last) w_nxt = S_BIAS;
      S_BIAS: w_nxt = S_ACT;
      S_ACT:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Operand capture needs no reset: contents only matter after a start.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_inp    <= inp;
      r_w      <= w;
      r_bias   <= bias;
      r_hidden <= hidden;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_acc <= '0;
          r_idx <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_sum;
          r_idx <= r_idx + IW'(LANES);
        end
        S_BIAS: r_acc <= r_acc + w_bias_sc;
        S_ACT: begin
          r_result <= w_y;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;
endmodule

// File: tb/tb_neuron_mac_engine.sv
// Directed bench for neuron_mac_engine: LANES=1 and LANES=4 instances, hand-computed results.
module tb_neuron_mac_engine;
  localparam int N  = 10;
  localparam int DW = 8;
`ifdef NEURON_LEAKY_RELU_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic            clk = 1'b0, rst = 1'b0, start_a = 1'b0, start_b = 1'b0, hidden = 1'b0;
  logic [DW*N-1:0] inp = '0, w = '0;
  logic [DW-1:0]   bias = '0;
  logic            busy_a, done_a, busy_b, done_b;
  logic [DW-1:0]   res_a, res_b;
  int              errors = 0, checks = 0;

  always #5 clk = ~clk;

  neuron_mac_engine #(.N(N), .DW(DW), .LANES(1), .FRAC(7), .ACC_W(21)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .inp(inp), .w(w), .bias(bias),
    .hidden(hidden), .busy(busy_a), .done(done_a), .result(res_a));
  neuron_mac_engine #(.N(N), .DW(DW), .LANES(4), .FRAC(7), .ACC_W(21)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .inp(inp), .w(w), .bias(bias),
    .hidden(hidden), .busy(busy_b), .done(done_b), .result(res_b));

  function automatic logic [DW*N-1:0] fill(input logic [DW-1:0] v);
    logic [DW*N-1:0] r;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic set_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] bi,
                         input logic h);
    inp = fill(a); w = fill(b); bias = bi; hidden = h;
  endtask

  task automatic run(input bit lb, input int exp_lat, input logic [7:0] exp_res, input string tag);
    int n;
    bit bsy_ok;
    if (lb) start_b = 1'b1; else start_a = 1'b1;
    step;
    start_a = 1'b0; start_b = 1'b0;
    n = 0; bsy_ok = 1'b1;
    while (n < 40) begin
      if (!(lb ? busy_b : busy_a)) bsy_ok = 1'b0;
      step; n++;
      if (lb ? done_b : done_a) break;
    end
    chk({tag, " lat"}, n, exp_lat);
    chk({tag, " busy"}, bsy_ok, 1);
    chk({tag, " idle"}, lb ? busy_b : busy_a, 0);
    chk({tag, " res"}, lb ? res_b : res_a, exp_res);
    step;
    chk({tag, " pulse"}, lb ? done_b : done_a, 0);
  endtask

  initial begin
    int n, cnt;
    #12;
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst res", res_a, 0);
    chk("rst res_b", res_b, 0);
    rst = 1'b1;
    step;

    set_vec(8'd1, 8'd1, 8'd0, 1'b0);       run(0, 12, 8'd10, "t1_ones");
    set_vec(8'd16, 8'd8, 8'd2, 1'b1);      run(0, 12, 8'd12, "t2_hidden");
    set_vec(8'd64, 8'd64, 8'd1, 1'b1);     run(0, 12, 8'd127, "t3_sat");
    set_vec(8'(-5), 8'd3, 8'd0, 1'b0);     run(0, 12, LK ? 8'hED : 8'h00, "t3_neg");
    set_vec(8'(-5), 8'd3, 8'd0, 1'b1);     run(0, 12, LK ? 8'hFF : 8'h00, "neg_hidden");
    set_vec(8'(-128), 8'd127, 8'd0, 1'b0); run(0, 12, LK ? 8'h80 : 8'h00, "neg_clamp");
    set_vec(8'd1, 8'd1, 8'(-1), 1'b0);     run(0, 12, LK ? 8'hF1 : 8'h00, "neg_bias");

    // single element 127*127 plus scaled bias lands on 127 and 128 after the shift
    set_vec(8'd0, 8'd0, 8'd1, 1'b1);
    inp[7:0] = 8'd127; w[7:0] = 8'd127;    run(0, 12, 8'd127, "edge127");
    bias = 8'd2;                           run(0, 12, 8'd127, "edge128");

    // mixed signs per position: 3*(1..5) - (6..10) = 5
    set_vec(8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      inp[DW*i +: DW] = 8'(i + 1);
      w[DW*i +: DW]   = (i < 5) ? 8'd3 : 8'hFF;
    end
    run(0, 12, 8'd5, "mixed_a");
    run(1, 5, 8'd5, "mixed_b");
    for (int i = 0; i < N; i++) begin
      inp[DW*i +: DW] = 8'(i);
      w[DW*i +: DW]   = 8'd1;
    end
    run(1, 5, 8'd45, "ramp_b");
    set_vec(8'd1, 8'd1, 8'd0, 1'b0);       run(1, 5, 8'd10, "t4_lanes4");

    // start held high: re-accepted in the done cycle; inp change mid-run only affects run 2
    set_vec(8'd1, 8'd1, 8'd0, 1'b0);
    start_a = 1'b1;
    step;
    n = 0;
    while (n < 40) begin
      step; n++;
      if (n == 3) inp = fill(8'd2);
      if (done_a) break;
    end
    chk("t5_held lat1", n, 12);
    chk("t5_held res1", res_a, 10);
    step;
    start_a = 1'b0;
    chk("t5_held rebusy", busy_a, 1);
    n = 0;
    while (n < 40) begin
      step; n++;
      if (done_a) break;
    end
    chk("t5_held lat2", n, 12);
    chk("t5_held res2", res_a, 20);
    cnt = 0;
    repeat (15) begin step; if (done_a) cnt++; end
    chk("t5_held no3rd", cnt, 0);

    // start pulse while busy is ignored
    set_vec(8'd1, 8'd1, 8'd0, 1'b0);
    start_a = 1'b1;
    step;
    start_a = 1'b0;
    n = 0;
    while (n < 40) begin
      step; n++;
      if (n == 5) begin start_a = 1'b1; inp = fill(8'd3); end
      if (n == 6) start_a = 1'b0;
      if (done_a) break;
    end
    chk("t5_ign lat", n, 12);
    chk("t5_ign res", res_a, 10);
    cnt = 0;
    repeat (15) begin step; if (done_a) cnt++; end
    chk("t5_ign nodone", cnt, 0);
    chk("t5_ign idle", busy_a, 0);

    // asynchronous reset in the middle of MAC
    set_vec(8'd1, 8'd1, 8'd0, 1'b0);
    start_a = 1'b1;
    step;
    start_a = 1'b0;
    repeat (3) step;
    #3 rst = 1'b0;
    #1;
    chk("t6 busy", busy_a, 0);
    chk("t6 done", done_a, 0);
    chk("t6 res", res_a, 0);
    #2 rst = 1'b1;
    cnt = 0;
    repeat (20) begin step; if (done_a) cnt++; end
    chk("t6 nodone", cnt, 0);
    set_vec(8'd2, 8'd3, 8'd0, 1'b0);       run(0, 12, 8'd60, "t6_rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/neuron_mac_engine.md
Name: neuron_mac_engine

Overview:
Parametrised, multi-cycle neuron compute engine. Captures an N-element input vector and weight vector, accumulates signed products LANES at a time, then adds a scaled bias and applies an optional fixed-point rescale and a saturating ReLU activation. A start/busy/done handshake lets the layer controller sequence neurons without external offset counters. Sits between the layer input/weight memories and the next-layer input register.

Parameters:
N, 10, number of inputs/weights per neuron (>=1)
DW, 8, signed two's-complement width of input, weight, bias and result
LANES, 1, multipliers used per MAC cycle (1..N)
FRAC, 7, fractional bits of weights; used for bias scaling and the hidden-mode shift
ACC_W, 21, accumulator width; must be >= 2*DW + clog2(N) + 1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; accepted only when busy=0
inp  in  DW*N  input vector; element i = inp[DW*i +: DW]
w  in  DW*N  weight vector; same packing as inp
bias  in  DW  signed bias
hidden  in  1  1 = hidden-layer mode: arithmetic right shift by FRAC before activation
busy  out  1  high while a computation is in progress
done  out  1  one-cycle pulse when result is updated
result  out  DW  activated output; holds until the next done

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, index=0, busy=0, done=0, result=0. Captured operands are don't-care.
- States: IDLE -> MAC -> BIAS -> ACT -> IDLE.
- IDLE: busy=0. When start=1 at a rising edge, latch inp, w, bias and hidden into internal registers, clear acc and index, and go to MAC. While busy=1, port changes have no effect.
- MAC: busy=1. Each cycle, acc += sum over lanes l of sext(inp[index+l]*w[index+l]), using DW x DW signed products (2*DW bits) sign-extended to ACC_W. Lanes with index+l >= N contribute 0. Then index += LANES. Leave for BIAS after the cycle that processes the final element. This gives K = ceil(N/LANES) MAC cycles.
- BIAS: busy=1. acc += sext(bias) << FRAC. Go to ACT.
- ACT: busy=1.
  - s = hidden ? (acc >>> FRAC) : acc.
  - y = 0 if s < 0; y = 2^(DW-1)-1 if s > 2^(DW-1)-1; otherwise y = s[DW-1:0].
  - Register y into result, pulse done for one cycle, go to IDLE.
- Latency: done is high exactly K+2 cycles after the cycle in which start was sampled. In the done cycle busy=0, so a start sampled in that cycle is accepted, giving back-to-back throughput of one neuron per K+3 cycles.
- Accumulator arithmetic wraps modulo 2^ACC_W. The ACC_W constraint guarantees no wrap for any operands.
- start while busy=1: ignored; no queuing.
- Reset mid-operation: aborts immediately; no done is produced for the aborted neuron.

Optional Feature:
NEURON_LEAKY_RELU_EN. When defined, a negative s yields y = max(s >>> 3, -2^(DW-1)) (arithmetic shift, floor) instead of 0. The positive path is unchanged. When undefined, the block uses plain saturating ReLU as specified above.

Test Plan:
1. Defaults, all inp=1, w=1, bias=0, hidden=0, start pulse -> busy high 12 cycles; done on cycle 12; result=10.
2. Hidden mode: inp=16, w=8 for all 10 elements, bias=2, hidden=1 -> acc=1280+256=1536; 1536>>>7=12; result=12.
3. Saturation and negative inputs:
   - inp=64, w=64, bias=1, hidden=1 -> s=321; result=127.
   - inp=-5, w=3, bias=0, hidden=0 -> s=-150; result=0 (with NEURON_LEAKY_RELU_EN: result=-19=8'hED).
4. LANES=4, N=10, same stimulus as test 1 -> done after 5 cycles; result=10. Lanes 2-3 of the third MAC cycle contribute 0.
5. Handshake:
   - start held high through a run -> a second run begins in the done cycle; second done comes 12 cycles later.
   - start pulse mid-run while busy -> ignored.
   - inp changed mid-run -> result unaffected.
6. rst driven low during MAC cycle 4, asynchronous to clk -> busy=0, done=0, result=0 immediately. No done afterward until a new start; that run then produces the correct result.
